// File: rtl/otter_pkg.sv
// Shared OTTER core definitions: base opcodes and SYSTEM func3 encodings.
// Used by the control FSM and the instruction decoder.
package otter_pkg;

  typedef enum logic [6:0] {
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    OP_IMM = 7'b0010011,
    OP_RG3 = 7'b0110011,
    SYSTEM = 7'b1110011
  } opcode_t;

  localparam logic [2:0] F3_PRIV  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;
  localparam logic [2:0] F3_CSRRC = 3'b011;

endpackage

// File: rtl/cu_fsm_if.sv
// Control-unit bundle between the datapath/decoder and the control FSM.
// master = FSM side (drives strobes), slave = datapath side.
interface cu_fsm_if;
  logic       intr;
  logic       mie;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       PCWrite;
  logic       regWrite;
  logic       memWE2;
  logic       memRDEN1;
  logic       memRDEN2;
  logic       reset;
  logic       csr_WE;
  logic       int_taken;
  logic       mret_exec;

  modport master (
    input  intr, mie, opcode, func3,
    output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
           reset, csr_WE, int_taken, mret_exec
  );

  modport slave (
    output intr, mie, opcode, func3,
    input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
           reset, csr_WE, int_taken, mret_exec
  );
endinterface

// File: rtl/cu_fsm.sv
// Multicycle OTTER control FSM: INIT -> FETCH -> EXEC [-> WB] [-> INTR] -> FETCH.
// Mealy outputs decoded from state, opcode/func3 and the interrupt request.
module cu_fsm
  import otter_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  cu_fsm_if.master  bus
);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_INTR  = 3'd4;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_irq;

  // Interrupts are only taken at instruction boundaries, with mie as seen this cycle.
  assign w_irq = bus.intr & bus.mie;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_INIT;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = ST_FETCH;
    bus.PCWrite   = 1'b0;
    bus.regWrite  = 1'b0;
    bus.memWE2    = 1'b0;
    bus.memRDEN1  = 1'b0;
    bus.memRDEN2  = 1'b0;
    bus.reset     = 1'b0;
    bus.csr_WE    = 1'b0;
    bus.int_taken = 1'b0;
    bus.mret_exec = 1'b0;

    case (r_state)
      ST_INIT: begin
        bus.reset = 1'b1;
        w_next    = ST_FETCH;
      end

      ST_FETCH: begin
        bus.memRDEN1 = 1'b1;
        w_next       = ST_EXEC;
      end

      ST_EXEC: begin
        w_next = w_irq ? ST_INTR : ST_FETCH;
        case (bus.opcode)
          LOAD: begin
            bus.memRDEN2 = 1'b1;
            w_next       = ST_WB;
          end
          STORE: begin
            bus.memWE2  = 1'b1;
            bus.PCWrite = 1'b1;
          end
          BRANCH: bus.PCWrite = 1'b1;
          LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: begin
            bus.regWrite = 1'b1;
            bus.PCWrite  = 1'b1;
          end
          SYSTEM: begin
            bus.PCWrite = 1'b1;
            case (bus.func3)
              F3_PRIV: bus.mret_exec = 1'b1;
              F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
                bus.csr_WE   = 1'b1;
                bus.regWrite = 1'b1;
              end
              default: ;
            endcase
          end
          default: bus.PCWrite = 1'b1;
        endcase
      end

      ST_WB: begin
        bus.regWrite = 1'b1;
        bus.PCWrite  = 1'b1;
        w_next       = w_irq ? ST_INTR : ST_FETCH;
      end

      ST_INTR: begin
        bus.int_taken = 1'b1;
        bus.PCWrite   = 1'b1;
        w_next        = ST_FETCH;
      end

      default: w_next = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_cu_fsm.sv
// Directed bench for cu_fsm: every output vector checked per cycle against hand-derived values.
module tb_cu_fsm;
  import otter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  cu_fsm_if bus ();

  cu_fsm dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec}
  localparam logic [8:0] O_PC   = 9'b100000000;
  localparam logic [8:0] O_RW   = 9'b010000000;
  localparam logic [8:0] O_WE2  = 9'b001000000;
  localparam logic [8:0] O_RD1  = 9'b000100000;
  localparam logic [8:0] O_RD2  = 9'b000010000;
  localparam logic [8:0] O_RST  = 9'b000001000;
  localparam logic [8:0] O_CSR  = 9'b000000100;
  localparam logic [8:0] O_INT  = 9'b000000010;
  localparam logic [8:0] O_MRET = 9'b000000001;

  logic [8:0] outs;
  assign outs = {bus.PCWrite, bus.regWrite, bus.memWE2, bus.memRDEN1, bus.memRDEN2,
                 bus.reset, bus.csr_WE, bus.int_taken, bus.mret_exec};

  task automatic test_reset_addi();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (outs !== O_RST) begin fails++; $display("FAIL reset_held got=%b exp=%b", outs, O_RST); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (outs !== O_RST) begin fails++; $display("FAIL init_cycle got=%b exp=%b", outs, O_RST); end
    @(negedge clk); bus.opcode = OP_IMM; bus.func3 = 3'b000; #1;
    checks++; if (outs !== O_RD1) begin fails++; $display("FAIL addi_fetch got=%b exp=%b", outs, O_RD1); end
    @(negedge clk); #1;
    checks++; if (outs !== (O_PC | O_RW)) begin fails++; $display("FAIL addi_exec got=%b exp=%b", outs, O_PC | O_RW); end
  endtask

  task automatic test_lw();
    @(negedge clk); bus.opcode = LOAD; bus.intr = 1'b0; #1;
    checks++; if (outs !== O_RD1) begin fails++; $display("FAIL lw_fetch got=%b exp=%b", outs, O_RD1); end
    @(negedge clk); #1;
    checks++; if (outs !== O_RD2) begin fails++; $display("FAIL lw_exec got=%b exp=%b", outs, O_RD2); end
    @(negedge clk); #1;
    checks++; if (outs !== (O_PC | O_RW)) begin fails++; $display("FAIL lw_wb got=%b exp=%b", outs, O_PC | O_RW); end
  endtask

  task automatic test_sw_intr();
    @(negedge clk); bus.opcode = STORE; bus.intr = 1'b1; bus.mie = 1'b1; #1;
    checks++; if (outs !== O_RD1) begin fails++; $display("FAIL sw_fetch_ignores_intr got=%b exp=%b", outs, O_RD1); end
    @(negedge clk); #1;
    checks++; if (outs !== (O_PC | O_WE2)) begin fails++; $display("FAIL sw_exec got=%b exp=%b", outs, O_PC | O_WE2); end
    @(negedge clk); #1;
    checks++; if (outs !== (O_PC | O_INT)) begin fails++; $display("FAIL sw_intr got=%b exp=%b", outs, O_PC | O_INT); end
    bus.intr = 1'b0;
  endtask

  task automatic test_lw_intr_at_wb();
    @(negedge clk); bus.opcode = LOAD; bus.intr = 1'b1; bus.mie = 1'b1; #1;
    checks++; if (outs !== O_RD1) begin fails++; $display("FAIL lwi_fetch got=%b exp=%b", outs, O_RD1); end
    @(negedge clk); #1;
    checks++; if (outs !== O_RD2) begin fails++; $display("FAIL lwi_exec_no_abort got=%b exp=%b", outs, O_RD2); end
    @(negedge clk); #1;
    checks++; if (outs !== (O_PC | O_RW)) begin fails++; $display("FAIL lwi_wb got=%b exp=%b", outs, O_PC | O_RW); end
    @(negedge clk); #1;
    checks++; if (outs !== (O_PC | O_INT)) begin fails++; $display("FAIL lwi_intr got=%b exp=%b", outs, O_PC | O_INT); end
    bus.intr = 1'b0;
  endtask

  task automatic test_beq_masked();
    bus.intr = 1'b1; bus.mie = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); bus.opcode = BRANCH; #1;
      checks++; if (outs !== O_RD1) begin fails++; $display("FAIL beq_fetch k=%0d got=%b exp=%b", k, outs, O_RD1); end
      @(negedge clk); #1;
      checks++; if (outs !== O_PC) begin fails++; $display("FAIL beq_exec k=%0d got=%b exp=%b", k, outs, O_PC); end
    end
  endtask

  task automatic test_system();
    @(negedge clk); bus.opcode = SYSTEM; bus.func3 = F3_PRIV; bus.intr = 1'b1; bus.mie = 1'b0; #1;
    checks++; if (outs !== O_RD1) begin fails++; $display("FAIL mret_fetch got=%b exp=%b", outs, O_RD1); end
    @(negedge clk); #1;
    checks++; if (outs !== (O_PC | O_MRET)) begin fails++; $display("FAIL mret_exec got=%b exp=%b", outs, O_PC | O_MRET); end
    @(negedge clk); bus.func3 = F3_CSRRW; bus.intr = 1'b0; #1;
    checks++; if (outs !== O_RD1) begin fails++; $display("FAIL mret_next_fetch got=%b exp=%b", outs, O_RD1); end
    @(negedge clk); #1;
    checks++; if (outs !== (O_PC | O_RW | O_CSR)) begin fails++; $display("FAIL csrrw_exec got=%b exp=%b", outs, O_PC | O_RW | O_CSR); end
    @(negedge clk); bus.func3 = 3'b101; #1;
    checks++; if (outs !== O_RD1) begin fails++; $display("FAIL csrrwi_fetch got=%b exp=%b", outs, O_RD1); end
    @(negedge clk); #1;
    checks++; if (outs !== O_PC) begin fails++; $display("FAIL sys_other_f3 got=%b exp=%b", outs, O_PC); end
    // MRET with intr and mie both high: MRET completes, then the trap is entered.
    @(negedge clk); bus.func3 = F3_PRIV; bus.intr = 1'b1; bus.mie = 1'b1; #1;
    checks++; if (outs !== O_RD1) begin fails++; $display("FAIL mret2_fetch got=%b exp=%b", outs, O_RD1); end
    @(negedge clk); #1;
    checks++; if (outs !== (O_PC | O_MRET)) begin fails++; $display("FAIL mret2_exec got=%b exp=%b", outs, O_PC | O_MRET); end
    @(negedge clk); bus.intr = 1'b0; #1;
    checks++; if (outs !== (O_PC | O_INT)) begin fails++; $display("FAIL mret2_intr got=%b exp=%b", outs, O_PC | O_INT); end
  endtask

  task automatic test_unknown_opcode();
    @(negedge clk); bus.opcode = 7'b0001111; bus.intr = 1'b0; #1;
    checks++; if (outs !== O_RD1) begin fails++; $display("FAIL nop_fetch got=%b exp=%b", outs, O_RD1); end
    @(negedge clk); #1;
    checks++; if (outs !== O_PC) begin fails++; $display("FAIL nop_exec got=%b exp=%b", outs, O_PC); end
  endtask

  task automatic test_rst_mid_wb();
    @(negedge clk); bus.opcode = LOAD; bus.intr = 1'b0; #1;
    checks++; if (outs !== O_RD1) begin fails++; $display("FAIL rwb_fetch got=%b exp=%b", outs, O_RD1); end
    @(negedge clk); #1;
    checks++; if (outs !== O_RD2) begin fails++; $display("FAIL rwb_exec got=%b exp=%b", outs, O_RD2); end
    @(negedge clk); #1;
    checks++; if (outs !== (O_PC | O_RW)) begin fails++; $display("FAIL rwb_wb got=%b exp=%b", outs, O_PC | O_RW); end
    rst = 1'b1; #1;
    checks++; if (outs !== O_RST) begin fails++; $display("FAIL rwb_async_reset got=%b exp=%b", outs, O_RST); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (outs !== O_RST) begin fails++; $display("FAIL rwb_init got=%b exp=%b", outs, O_RST); end
    @(negedge clk); #1;
    checks++; if (outs !== O_RD1) begin fails++; $display("FAIL rwb_refetch got=%b exp=%b", outs, O_RD1); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst        = 1'b1;
    bus.intr   = 1'b0;
    bus.mie    = 1'b0;
    bus.opcode = 7'b0000000;
    bus.func3  = 3'b000;
    test_reset_addi();
    test_lw();
    test_sw_intr();
    test_lw_intr_at_wb();
    test_beq_masked();
    test_system();
    test_unknown_opcode();
    test_rst_mid_wb();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
